// File: rtl/pkt_fifo_pkg.sv
// pkt_fifo_pkg: shared constants, the stored-entry layout and a header
// length helper for the packet-aware router output FIFO.
//   DATA_W_DEF / DEPTH_DEF / LEN_MSB_DEF / LEN_LSB_DEF : default geometry
//   entry_t   : one stored word, {sof, data}
//   hdr_len() : payload-length field of a header word (default geometry)
package pkt_fifo_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int DEPTH_DEF   = 16;
  localparam int LEN_MSB_DEF = 7;
  localparam int LEN_LSB_DEF = 2;
  localparam int LEN_W_DEF   = LEN_MSB_DEF - LEN_LSB_DEF + 1;

  typedef struct packed {
    logic                  sof;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

  function automatic logic [LEN_W_DEF-1:0] hdr_len(input logic [DATA_W_DEF-1:0] hdr);
    return hdr[LEN_MSB_DEF:LEN_LSB_DEF];
  endfunction

endpackage

// File: rtl/pkt_fifo_mem.sv
// pkt_fifo_mem: simple dual-port register array, one write port and one
// registered read port. Contents are not reset; only the read register is.
//   clk   : rising-edge clock
//   clr   : synchronous clear of the read register (reset or flush)
//   we    : write enable, waddr/wdata : write address/data
//   re    : read enable,  raddr       : read address
//   rdata : registered read data, holds when re is low
// A read and a write to the same address on one edge return the old word.
module pkt_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/pkt_fifo.sv
// pkt_fifo: packet-aware FIFO for a router output channel. Every word is
// stored with a start-of-packet tag; on read the header length is decoded
// to find the parity byte that closes each packet.
//   clk, rst (sync, active-high), soft_rst (sync flush, active-high)
//   wr_en, lfd_state, din    : write side (lfd_state tags din as a header)
//   rd_en                    : read side
//   dout, dout_valid         : registered read data, 1-cycle valid pulse
//   dout_sof, pkt_done       : popped word was a header / closed a packet
//   full, empty, almost_full, count : occupancy status
//   ovf_err, udf_err         : sticky errors, present only when the macro
//                              PKT_FIFO_ERR_EN is defined (else tied to 0)
//
// Handshake: a write is accepted on an edge when wr_en && (!full || read
// accepted); a read is accepted when rd_en && !empty. Requests that are not
// accepted are dropped, never queued. On empty with both requested only the
// write is taken. rst and soft_rst win over both requests.
module pkt_fifo
  import pkt_fifo_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int LEN_MSB  = LEN_MSB_DEF,
  parameter int LEN_LSB  = LEN_LSB_DEF,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AW       = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(DEPTH) + 1,
  parameter int LEN_W    = LEN_MSB - LEN_LSB + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_rst,
  input  logic              wr_en,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              dout_sof,
  output logic              pkt_done,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [CNT_W-1:0]  count,
  output logic              ovf_err,
  output logic              udf_err
);

  localparam int PC_W = LEN_W + 1;

  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            clr, wr_acc, rd_acc;
  logic [DATA_W:0] rd_entry;
  logic [PC_W-1:0] pkt_cnt, pkt_cnt_nxt;

  assign clr    = rst | soft_rst;
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign almost_full = (count >= CNT_W'(AF_LEVEL));

  pkt_fifo_mem #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .clr   (clr),
    .we    (wr_acc & ~clr),
    .waddr (wr_ptr),
    .wdata ({lfd_state, din}),
    .re    (rd_acc & ~clr),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  assign dout     = rd_entry[DATA_W-1:0];
  assign dout_sof = dout_valid & rd_entry[DATA_W];

  // The tracker works off the registered read word: while dout_valid is
  // high, pkt_cnt still holds the count from before this pop, and the pop's
  // effect is folded in on the following edge. This keeps the memory read
  // port purely registered while pkt_done still lines up with its word.
  assign pkt_done = dout_valid & ~rd_entry[DATA_W] & (pkt_cnt == PC_W'(1));

  always_comb begin
    pkt_cnt_nxt = pkt_cnt;
    if (dout_valid) begin
      if (rd_entry[DATA_W])
        // Header reload covers the payload plus the trailing parity byte;
        // any packet still in flight is truncated here.
        pkt_cnt_nxt = {1'b0, rd_entry[LEN_MSB:LEN_LSB]} + PC_W'(1);
      else if (pkt_cnt != '0)
        pkt_cnt_nxt = pkt_cnt - PC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      dout_valid <= 1'b0;
      pkt_cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      dout_valid <= rd_acc;
      pkt_cnt    <= pkt_cnt_nxt;
    end
  end

`ifdef PKT_FIFO_ERR_EN
  // Sticky through soft_rst; requests in a flush cycle are not judged.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else if (!soft_rst) begin
      if (wr_en && full && !rd_acc) ovf_err <= 1'b1;
      if (rd_en && empty)           udf_err <= 1'b1;
    end
  end
`else
  assign ovf_err = 1'b0;
  assign udf_err = 1'b0;
`endif

endmodule

// File: doc/pkt_fifo.md
# pkt_fifo

Parametrised, packet-aware FIFO for the router output channels; next generation of the per-port router FIFO. Stores a start-of-packet tag with every word, decodes the header length on read to track packet boundaries, and provides occupancy and almost-full status. Sits between the router synchroniser/FSM write side and each destination read port.

## Interface
- DATA_W, 8: data word width.
- DEPTH, 16: entries; power of two, at least 4.
- LEN_MSB, 7: MSB of the payload-length field in the header word.
- LEN_LSB, 2: LSB of the payload-length field; LEN_W = LEN_MSB-LEN_LSB+1.
- AF_LEVEL, DEPTH-2: occupancy at or above which almost_full asserts.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- soft_rst  in  1  synchronous flush, active-high (timeout flush from the router FSM).
- wr_en  in  1  write request.
- lfd_state  in  1  tags the word written this cycle as a header (start of packet).
- din  in  DATA_W  write data.
- rd_en  in  1  read request.
- dout  out  DATA_W  registered read data.
- dout_valid  out  1  dout was popped on the previous edge.
- dout_sof  out  1  the popped word was a header.
- pkt_done  out  1  the popped word closed a packet (parity byte).
- full, empty, almost_full  out  1  status flags.
- count  out  log2(DEPTH)+1  current occupancy.
- ovf_err, udf_err  out  1  sticky errors (only meaningful with PKT_FIFO_ERR_EN).

## Operation
- Storage: DEPTH entries of DATA_W+1 bits, {lfd_state, din}.
- Write accepted when wr_en && (!full || read accepted this cycle). Read accepted when rd_en && !empty. On empty with both requested, only the write is accepted.
- count: +1 on write only, -1 on read only, unchanged on both or neither.
- Pointers are log2(DEPTH) bits wide and wrap naturally.
- Flags decode from registered count: full = (count==DEPTH), empty = (count==0), almost_full = (count>=AF_LEVEL).
- Packet tracker pkt_cnt (LEN_W+1 bits):
  - Popping a header loads header[LEN_MSB:LEN_LSB]+1, which covers the payload plus the parity byte.
  - Popping a non-header with pkt_cnt>0 decrements it.
  - pkt_done asserts with the pop that takes pkt_cnt from 1 to 0.
  - A header popped while pkt_cnt!=0 reloads the counter; the previous packet is truncated and gets no pkt_done.
  - A non-header popped while pkt_cnt==0 is an orphan: the data is still output, pkt_cnt stays 0.
- dout holds its last value when no read is accepted; dout_valid, dout_sof and pkt_done are single-cycle pulses.
- Priority order: rst, then soft_rst, then normal operation.
- rst and soft_rst clear pointers, count, pkt_cnt and all outputs to 0. Result: empty=1, full=0, almost_full=0 (AF_LEVEL>0), dout=0. Requests in the same cycle are ignored.
- soft_rst does not clear the sticky errors; only rst does.

## Timing
- Read latency is 1: pop on edge N gives dout, dout_valid, dout_sof and pkt_done valid after edge N.
- Write to flag update is 1 edge: empty deasserts after the edge that accepts the first write.
- Full is reached after the DEPTH-th accepted write. A write at full with a simultaneous read is accepted and full stays 1.
- Memory write and pointer updates happen on the same edge as acceptance. There is no combinational path from din to dout.

## Configuration
- PKT_FIFO_ERR_EN defined:
  - ovf_err sets on wr_en while full with no accepted read.
  - udf_err sets on rd_en while empty.
  - Both are sticky until rst.
- PKT_FIFO_ERR_EN undefined: ovf_err and udf_err are tied to 0 and their detection logic is removed. Dropped and ignored requests stay silent.

## Structure
- Package pkt_fifo_pkg holds:
  - default DATA_W, DEPTH, LEN_MSB and LEN_LSB constants;
  - typedef of the stored entry {sof, data};
  - a function extracting the length field from a header word.
- Sub-module pkt_fifo_mem: simple dual-port register array with one write port and one registered read port, parametrised on width and depth. Pointers, count, flags and the packet tracker live in pkt_fifo.

## Test plan
- Reset: assert rst for 2 cycles while wr_en=1 -> count=0, empty=1, dout=0, nothing stored.
- Packet pass-through: write header 8'h0C (len 3) with lfd_state=1, then 8'hA1, A2, A3 and parity 8'h5E; read 5 -> dout in order, dout_sof only on 8'h0C, pkt_done only on 8'h5E.
- Full and wrap: with DEPTH=16, write 16 words -> full=1, almost_full from count=14. 17th write dropped (ovf_err=1 with ERR_EN). Read 16, write 16 and read 16 again -> data intact across the pointer wrap.
- Simultaneous ops: at full, rd_en and wr_en together -> count stays 16 and the new word is read last. At empty, both together -> count=1, dout_valid=0.
- soft_rst mid-packet: header 8'h14 written, 2 of 6 words read, then soft_rst -> count=0, pkt_cnt=0. The next header and packet work normally, with no spurious pkt_done.
- Truncation and orphan: header 8'h08, 1 payload, then new header 8'h04 -> counter reloads, pkt_done only at the end of the second packet. A non-header pop with pkt_cnt=0 gives dout with no pkt_done.
